// File: rtl/isp_program_loader.sv
// Framed serial byte stream -> 32-bit instruction memory writes, then a start pulse on a good checksum.
// Frame: SYNC, LEN_LO, LEN_HI, N x 4 data bytes (LSB first), CSUM; one byte-cycle of backpressure per written word.
module isp_program_loader #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDRESS_BITS = 12,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          PROG_BASE    = 0,
  parameter logic [19:0] START_ADDR   = 20'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    start,
  output logic [19:0]             prog_address,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_START, S_DONE, S_ERROR
  } state_t;

  // Largest frame that still fits between PROG_BASE and the top of memory.
  localparam logic [31:0] MAX_WORDS = 32'((1 << ADDRESS_BITS) - PROG_BASE);

  state_t                  r_state;
  state_t                  w_next;
  logic [15:0]             r_len;
  logic [7:0]              r_sum;
  logic [1:0]              r_cnt;
  logic [ADDRESS_BITS:0]   r_word_idx;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [ADDRESS_BITS-1:0] r_isp_address;
  logic [DATA_WIDTH-1:0]   r_isp_data;

  logic        w_xfer;
  logic        w_sync;
  logic [15:0] w_len;
  logic        w_last_word;

  assign w_xfer      = rx_valid & rx_ready;
  assign w_sync      = w_xfer && (rx_data == SYNC_BYTE);
  assign w_len       = {rx_data, r_len[7:0]};
  assign w_last_word = (32'(r_word_idx) == (32'(r_len) - 32'd1));

  assign isp_address = r_isp_address;
  assign isp_data    = r_isp_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    rx_ready     = 1'b1;
    isp_write    = 1'b0;
    start        = 1'b0;
    prog_address = 20'h0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_sync) w_next = S_LEN_LO;
      end
      S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer) begin
          if (32'(w_len) > MAX_WORDS) w_next = S_ERROR;
          else if (w_len == 16'd0)    w_next = S_CSUM;
          else                        w_next = S_DATA;
        end
      end
      S_DATA: if (w_xfer && (r_cnt == 2'd3)) w_next = S_WRITE;
      S_WRITE: begin
        rx_ready  = 1'b0;
        isp_write = 1'b1;
        w_next    = w_last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: if (w_xfer) w_next = (rx_data == r_sum) ? S_START : S_ERROR;
      S_START: begin
        rx_ready     = 1'b0;
        start        = 1'b1;
        prog_address = START_ADDR;
        w_next       = S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (w_sync) w_next = S_LEN_LO;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len         <= '0;
      r_sum         <= '0;
      r_cnt         <= '0;
      r_word_idx    <= '0;
      r_word        <= '0;
      r_isp_address <= '0;
      r_isp_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_sync) begin
            r_len      <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_word     <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= rx_data;
            r_sum      <= r_sum + rx_data;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= rx_data;
            r_sum       <= r_sum + rx_data;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word[{r_cnt, 3'b000} +: 8] <= rx_data;
            r_sum <= r_sum + rx_data;
            r_cnt <= r_cnt + 2'd1;
            // Latch the finished word here so the WRITE cycle presents stable address/data.
            if (r_cnt == 2'd3) begin
              r_isp_address <= ADDRESS_BITS'(PROG_BASE) + r_word_idx[ADDRESS_BITS-1:0];
              r_isp_data    <= {rx_data, r_word[23:0]};
            end
          end
        end
        S_WRITE: r_word_idx <= r_word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_program_loader.sv
// Directed bench for isp_program_loader: good/bad frames, junk bytes, length limits, stalls, mid-frame reset.
module tb_isp_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        isp_write;
  logic [11:0] isp_address;
  logic [31:0] isp_data;
  logic        start;
  logic [19:0] prog_address;
  logic        busy;
  logic        done;
  logic        error;

  isp_program_loader dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .isp_write(isp_write), .isp_address(isp_address),
    .isp_data(isp_data), .start(start), .prog_address(prog_address),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor: logs every write strobe and start pulse; counts rx_ready glitches
  // (rx_ready must be low exactly on write/start cycles).
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          n_start = 0;
  int          n_rdy_viol = 0;
  logic [31:0] last_prog_addr = 32'hFFFF_FFFF;

  always @(negedge clock) begin
    if (isp_write) begin
      wr_addr_q.push_back(32'(isp_address));
      wr_data_q.push_back(isp_data);
    end
    if (start) begin
      n_start++;
      last_prog_addr = 32'(prog_address);
    end
    if (rx_ready == (isp_write | start)) n_rdy_viol++;
  end

  // Frame from bring-up: two words 00000513, 00100593; byte sum of LEN+data = 0xC2.
  logic [7:0] frame_a [11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                               8'h93, 8'h05, 8'h10, 8'h00};
  localparam logic [7:0] GOOD_CSUM = 8'hC2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one byte after 'gap' idle cycles; returns on the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int i = 0; i < gap; i++) @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    while (!rx_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) chk("rdy_timeout", 32'(rx_ready), 32'd1);
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame_a(input logic [7:0] csum, input int maxgap);
    for (int i = 0; i < 11; i++) send_byte(frame_a[i], $urandom_range(0, maxgap));
    send_byte(csum, $urandom_range(0, maxgap));
  endtask

  task automatic check_frame_a_writes(input string tag, input int base);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(base + 2));
    if (wr_addr_q.size() >= base + 2) begin
      chk({tag, "_a0"}, wr_addr_q[base],     32'd0);
      chk({tag, "_d0"}, wr_data_q[base],     32'h0000_0513);
      chk({tag, "_a1"}, wr_addr_q[base + 1], 32'd1);
      chk({tag, "_d1"}, wr_data_q[base + 1], 32'h0010_0593);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},  32'(rx_ready),     32'd1);
    chk({tag, "_wr"},   32'(isp_write),    32'd0);
    chk({tag, "_addr"}, 32'(isp_address),  32'd0);
    chk({tag, "_data"}, isp_data,          32'd0);
    chk({tag, "_st"},   32'(start),        32'd0);
    chk({tag, "_pa"},   32'(prog_address), 32'd0);
    chk({tag, "_flags"}, {29'd0, busy, done, error}, 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  int base_wr;
  int base_st;

  initial begin
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: good frame, back-to-back bytes
    base_wr = wr_addr_q.size();
    base_st = n_start;
    send_frame_a(GOOD_CSUM, 0);
    chk("t1_start_now", 32'(start), 32'd1);
    chk("t1_prog_addr", 32'(prog_address), 32'd0);
    @(negedge clock);
    chk("t1_start_once", 32'(n_start - base_st), 32'd1);
    chk("t1_done", {29'd0, busy, done, error}, 32'b010);
    check_frame_a_writes("t1", base_wr);

    // 3: junk while done (dropped, done held), then empty frame
    base_wr = wr_addr_q.size();
    base_st = n_start;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    chk("t3_done_held", 32'(done), 32'd1);
    send_byte(8'hA5, 0);
    chk("t3_done_clr", {29'd0, busy, done, error}, 32'b100);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t3_start", 32'(start), 32'd1);
    @(negedge clock);
    chk("t3_nwr", 32'(wr_addr_q.size() - base_wr), 32'd0);
    chk("t3_nstart", 32'(n_start - base_st), 32'd1);
    chk("t3_done", 32'(done), 32'd1);

    // 5: random stalls of 0-5 cycles
    base_wr = wr_addr_q.size();
    base_st = n_start;
    send_frame_a(GOOD_CSUM, 5);
    chk("t5_start_now", 32'(start), 32'd1);
    @(negedge clock);
    chk("t5_nstart", 32'(n_start - base_st), 32'd1);
    check_frame_a_writes("t5", base_wr);
    chk("t5_rdy_rule", 32'(n_rdy_viol), 32'd0);

    // 2: bad checksum -> writes kept, sticky error, no start, later SYNC ignored
    base_wr = wr_addr_q.size();
    base_st = n_start;
    send_frame_a(8'hBC, 0);
    @(negedge clock);
    check_frame_a_writes("t2", base_wr);
    chk("t2_err", {29'd0, busy, done, error}, 32'b001);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    chk("t2_err_sticky", {29'd0, busy, done, error}, 32'b001);
    chk("t2_nstart", 32'(n_start - base_st), 32'd0);
    do_reset();

    // 4: N = 0x1001 exceeds 4096-word memory
    base_wr = wr_addr_q.size();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    chk("t4_err", 32'(error), 32'd1);
    chk("t4_rdy", 32'(rx_ready), 32'd1);
    chk("t4_nwr", 32'(wr_addr_q.size() - base_wr), 32'd0);
    do_reset();

    // N = 0x1000 is exactly the memory size and is accepted
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    chk("max_len_busy", {29'd0, busy, done, error}, 32'b100);

    // 6: reset after two data bytes of word 0
    do_reset();
    base_wr = wr_addr_q.size();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_rst");
    @(negedge clock);
    reset = 1'b0;
    base_st = n_start;
    send_frame_a(GOOD_CSUM, 1);
    chk("t6_start_now", 32'(start), 32'd1);
    @(negedge clock);
    check_frame_a_writes("t6", base_wr);
    chk("t6_done", 32'(done), 32'd1);
    chk("last_prog_addr", last_prog_addr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
